// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline-stage registers: control bit
// positions, per-stage bundle widths, the bubble constant and skid states.
package pipe_pkg;

    // Control bundle bit positions
    localparam int REGDST    = 0;
    localparam int ALUSRC    = 1;
    localparam int MEMTOREG  = 2;
    localparam int REGWRITE  = 3;
    localparam int MEMREAD   = 4;
    localparam int MEMWRITE  = 5;
    localparam int ALUOP_LSB = 6;
    localparam int ALUOP_MSB = 7;

    // Default bundle widths per pipeline boundary
    localparam int IFID_CTRL_W  = 8;
    localparam int IFID_DATA_W  = 64;   // pc+4, instruction
    localparam int IDEX_CTRL_W  = 8;
    localparam int IDEX_DATA_W  = 111;  // RS, RT, signextend, RSaddr, RTaddr, RDaddr
    localparam int EXMEM_CTRL_W = 8;
    localparam int EXMEM_DATA_W = 70;   // alu result, store data, dest, zero
    localparam int MEMWB_CTRL_W = 8;
    localparam int MEMWB_DATA_W = 69;   // load data, alu result, dest

    // All-zero control word; a bubble carries this so it can never write state.
    // Wide enough to be sliced down to any supported CTRL_W.
    localparam int          CTRL_MAX_W  = 64;
    localparam logic [63:0] CTRL_BUBBLE = 64'h0;

    // Occupancy of the two-entry skid buffer; the encoding is the entry count
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry head/skid storage with a registered ready. The head (H) drives the
// outputs; the skid (S) catches the beat accepted while H is stalled.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 111
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    localparam logic [CTRL_W-1:0] BUBBLE_C = CTRL_BUBBLE[CTRL_W-1:0];

    skid_state_e       state_r, state_s;
    logic [CTRL_W-1:0] h_ctrl_r, h_ctrl_s, s_ctrl_r, s_ctrl_s;
    logic [DATA_W-1:0] h_data_r, h_data_s, s_data_r, s_data_s;
    logic              ready_r, ready_s;
    logic              accept_s, release_s;

    assign accept_s  = in_valid_i & ready_r;
    assign release_s = (state_r != ST_EMPTY) & out_ready_i;

    // Next-state and entry-update logic; flush overrides every handshake
    always_comb begin
        state_s  = state_r;
        h_ctrl_s = h_ctrl_r;
        h_data_s = h_data_r;
        s_ctrl_s = s_ctrl_r;
        s_data_s = s_data_r;
        if (flush_i) begin
            state_s  = ST_EMPTY;
            h_ctrl_s = BUBBLE_C;
            s_ctrl_s = BUBBLE_C;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_s  = ST_ONE;
                        h_ctrl_s = in_ctrl_i;
                        h_data_s = in_data_i;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && release_s) begin
                        h_ctrl_s = in_ctrl_i;
                        h_data_s = in_data_i;
                    end else if (accept_s) begin
                        state_s  = ST_FULL;
                        s_ctrl_s = in_ctrl_i;
                        s_data_s = in_data_i;
                    end else if (release_s) begin
                        state_s  = ST_EMPTY;
                        h_ctrl_s = BUBBLE_C;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // ready is low here, so only a release can move us
                    if (release_s) begin
                        state_s  = ST_ONE;
                        h_ctrl_s = s_ctrl_r;
                        h_data_s = s_data_r;
                        s_ctrl_s = BUBBLE_C;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s  = ST_EMPTY;
                    h_ctrl_s = BUBBLE_C;
                    s_ctrl_s = BUBBLE_C;
                end
            endcase
        end
        ready_s = (state_s != ST_FULL);
    end

    // Entry and occupancy registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= ST_EMPTY;
            h_ctrl_r <= BUBBLE_C;
            h_data_r <= {DATA_W{1'b0}};
            s_ctrl_r <= BUBBLE_C;
            s_data_r <= {DATA_W{1'b0}};
            ready_r  <= 1'b1;
        end else begin
            state_r  <= state_s;
            h_ctrl_r <= h_ctrl_s;
            h_data_r <= h_data_s;
            s_ctrl_r <= s_ctrl_s;
            s_data_r <= s_data_s;
            ready_r  <= ready_s;
        end
    end

    assign in_ready_o  = ready_r;
    assign out_valid_o = (state_r != ST_EMPTY);
    assign out_ctrl_o  = h_ctrl_r;
    assign out_data_o  = h_data_r;
    assign count_o     = state_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid, flush (bubble insertion)
// and stall. SKID=1 uses a two-entry skid buffer with a registered ready;
// SKID=0 is a single register whose ready follows out_ready_i directly.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 111,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    if (SKID != 0) begin : g_skid
        pipe_skid_buf #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_skid (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .flush_i     (flush_i),
            .in_valid_i  (in_valid_i),
            .in_ready_o  (in_ready_o),
            .in_ctrl_i   (in_ctrl_i),
            .in_data_i   (in_data_i),
            .out_valid_o (out_valid_o),
            .out_ready_i (out_ready_i),
            .out_ctrl_o  (out_ctrl_o),
            .out_data_o  (out_data_o),
            .count_o     (count_o)
        );
    end else begin : g_reg
        localparam logic [CTRL_W-1:0] BUBBLE_C = CTRL_BUBBLE[CTRL_W-1:0];

        logic              valid_r;
        logic [CTRL_W-1:0] ctrl_r;
        logic [DATA_W-1:0] data_r;
        logic              ready_s;
        logic              accept_s;
        logic              release_s;

        assign ready_s   = ~valid_r | out_ready_i;
        assign accept_s  = in_valid_i & ready_s;
        assign release_s = valid_r & out_ready_i;

        // Single head register: flush, then load, then drain to a bubble
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_r <= 1'b0;
                ctrl_r  <= BUBBLE_C;
                data_r  <= {DATA_W{1'b0}};
            end else if (flush_i) begin
                valid_r <= 1'b0;
                ctrl_r  <= BUBBLE_C;
            end else if (accept_s) begin
                valid_r <= 1'b1;
                ctrl_r  <= in_ctrl_i;
                data_r  <= in_data_i;
            end else if (release_s) begin
                valid_r <= 1'b0;
                ctrl_r  <= BUBBLE_C;
            end else begin
                valid_r <= valid_r;
            end
        end

        assign in_ready_o  = ready_s;
        assign out_valid_o = valid_r;
        assign out_ctrl_o  = ctrl_r;
        assign out_data_o  = data_r;
        assign count_o     = {1'b0, valid_r};
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one instance with the skid buffer and one
// single-register instance, each stimulated and checked by scenario tasks.
module tb_pipe_stage_reg;

    logic         clk;
    logic         rst;

    logic         s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
    logic [7:0]   s1_in_ctrl, s1_out_ctrl;
    logic [110:0] s1_in_data, s1_out_data;
    logic [1:0]   s1_count;

    logic         s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
    logic [7:0]   s0_in_ctrl, s0_out_ctrl;
    logic [110:0] s0_in_data, s0_out_data;
    logic [1:0]   s0_count;

    int vec_cnt = 0;
    int err_cnt = 0;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(111), .SKID(1)) u_dut_skid (
        .clk_i(clk), .rst_i(rst), .flush_i(s1_flush),
        .in_valid_i(s1_in_valid), .in_ready_o(s1_in_ready),
        .in_ctrl_i(s1_in_ctrl), .in_data_i(s1_in_data),
        .out_valid_o(s1_out_valid), .out_ready_i(s1_out_ready),
        .out_ctrl_o(s1_out_ctrl), .out_data_o(s1_out_data), .count_o(s1_count)
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(111), .SKID(0)) u_dut_reg (
        .clk_i(clk), .rst_i(rst), .flush_i(s0_flush),
        .in_valid_i(s0_in_valid), .in_ready_o(s0_in_ready),
        .in_ctrl_i(s0_in_ctrl), .in_data_i(s0_in_data),
        .out_valid_o(s0_out_valid), .out_ready_i(s0_out_ready),
        .out_ctrl_o(s0_out_ctrl), .out_data_o(s0_out_data), .count_o(s0_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s1_flush = 1'b0; s1_in_valid = 1'b0; s1_out_ready = 1'b0; s1_in_ctrl = 8'h00; s1_in_data = 111'd0;
        s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0; s0_in_ctrl = 8'h00; s0_in_data = 111'd0;
        tick();
        vec_cnt++; if (s1_out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_s1_valid got %0b exp 0", s1_out_valid); end
        vec_cnt++; if (s1_out_ctrl !== 8'h00) begin err_cnt++; $display("FAIL reset_s1_ctrl got %h exp 00", s1_out_ctrl); end
        vec_cnt++; if (s1_out_data !== 111'd0) begin err_cnt++; $display("FAIL reset_s1_data got %h exp 0", s1_out_data); end
        vec_cnt++; if (s1_count !== 2'd0) begin err_cnt++; $display("FAIL reset_s1_count got %0d exp 0", s1_count); end
        vec_cnt++; if (s0_out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_s0_valid got %0b exp 0", s0_out_valid); end
        vec_cnt++; if (s0_count !== 2'd0) begin err_cnt++; $display("FAIL reset_s0_count got %0d exp 0", s0_count); end
        rst = 1'b0;
        #1;
        vec_cnt++; if (s1_in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_s1_ready got %0b exp 1", s1_in_ready); end
        vec_cnt++; if (s0_in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_s0_ready got %0b exp 1", s0_in_ready); end
    endtask

    task automatic test_stream();
        s1_in_valid = 1'b1; s1_out_ready = 1'b1; s1_in_ctrl = 8'h28; s1_in_data = 111'd1;
        s0_in_valid = 1'b1; s0_out_ready = 1'b1; s0_in_ctrl = 8'h28; s0_in_data = 111'd1;
        #1;
        vec_cnt++; if (s1_out_ctrl !== 8'h00) begin err_cnt++; $display("FAIL stream_pre_s1_ctrl got %h exp 00", s1_out_ctrl); end
        vec_cnt++; if (s0_out_ctrl !== 8'h00) begin err_cnt++; $display("FAIL stream_pre_s0_ctrl got %h exp 00", s0_out_ctrl); end
        for (int i = 1; i <= 4; i++) begin
            logic [110:0] exp_d;
            exp_d = 111'(i);
            s1_in_data = exp_d;
            s0_in_data = exp_d;
            tick();
            vec_cnt++; if (s1_out_valid !== 1'b1 || s1_out_ctrl !== 8'h28 || s1_out_data !== exp_d) begin
                err_cnt++; $display("FAIL stream_s1_beat got v=%0b c=%h d=%0d exp v=1 c=28 d=%0d", s1_out_valid, s1_out_ctrl, s1_out_data, exp_d); end
            vec_cnt++; if (s1_count !== 2'd1) begin err_cnt++; $display("FAIL stream_s1_count got %0d exp 1", s1_count); end
            vec_cnt++; if (s0_out_valid !== 1'b1 || s0_out_ctrl !== 8'h28 || s0_out_data !== exp_d) begin
                err_cnt++; $display("FAIL stream_s0_beat got v=%0b c=%h d=%0d exp v=1 c=28 d=%0d", s0_out_valid, s0_out_ctrl, s0_out_data, exp_d); end
            vec_cnt++; if (s0_count !== 2'd1) begin err_cnt++; $display("FAIL stream_s0_count got %0d exp 1", s0_count); end
        end
        s1_in_valid = 1'b0; s0_in_valid = 1'b0;
        tick();
        vec_cnt++; if (s1_out_valid !== 1'b0 || s1_count !== 2'd0) begin err_cnt++; $display("FAIL stream_s1_drain got v=%0b n=%0d exp v=0 n=0", s1_out_valid, s1_count); end
        vec_cnt++; if (s0_out_valid !== 1'b0 || s0_count !== 2'd0) begin err_cnt++; $display("FAIL stream_s0_drain got v=%0b n=%0d exp v=0 n=0", s0_out_valid, s0_count); end
    endtask

    task automatic test_stall();
        s1_in_valid = 1'b1; s1_in_ctrl = 8'h28; s1_in_data = 111'd5; s1_out_ready = 1'b1;
        tick();
        vec_cnt++; if (s1_count !== 2'd1 || s1_out_data !== 111'd5) begin err_cnt++; $display("FAIL stall_first got n=%0d d=%0d exp n=1 d=5", s1_count, s1_out_data); end
        s1_in_data = 111'd6; s1_out_ready = 1'b0;
        tick();
        vec_cnt++; if (s1_count !== 2'd2) begin err_cnt++; $display("FAIL stall_full_count got %0d exp 2", s1_count); end
        vec_cnt++; if (s1_in_ready !== 1'b0) begin err_cnt++; $display("FAIL stall_ready_low got %0b exp 0", s1_in_ready); end
        s1_in_data = 111'd7;
        tick();
        vec_cnt++; if (s1_count !== 2'd2 || s1_out_data !== 111'd5) begin err_cnt++; $display("FAIL stall_hold got n=%0d d=%0d exp n=2 d=5", s1_count, s1_out_data); end
        s1_out_ready = 1'b1;
        tick();
        vec_cnt++; if (s1_out_valid !== 1'b1 || s1_out_data !== 111'd6 || s1_count !== 2'd1) begin
            err_cnt++; $display("FAIL stall_second got v=%0b d=%0d n=%0d exp v=1 d=6 n=1", s1_out_valid, s1_out_data, s1_count); end
        vec_cnt++; if (s1_in_ready !== 1'b1) begin err_cnt++; $display("FAIL stall_ready_back got %0b exp 1", s1_in_ready); end
        tick();
        vec_cnt++; if (s1_out_valid !== 1'b1 || s1_out_data !== 111'd7 || s1_count !== 2'd1) begin
            err_cnt++; $display("FAIL stall_third got v=%0b d=%0d n=%0d exp v=1 d=7 n=1", s1_out_valid, s1_out_data, s1_count); end
        s1_in_valid = 1'b0;
        tick();
        vec_cnt++; if (s1_out_valid !== 1'b0 || s1_count !== 2'd0) begin err_cnt++; $display("FAIL stall_drain got v=%0b n=%0d exp v=0 n=0", s1_out_valid, s1_count); end
    endtask

    task automatic test_flush();
        s1_in_valid = 1'b1; s1_in_ctrl = 8'h28; s1_in_data = 111'h11; s1_out_ready = 1'b0;
        tick();
        s1_in_data = 111'h12;
        tick();
        vec_cnt++; if (s1_count !== 2'd2) begin err_cnt++; $display("FAIL flush_fill got %0d exp 2", s1_count); end
        s1_flush = 1'b1; s1_in_data = 111'd9;
        s0_in_valid = 1'b1; s0_in_ctrl = 8'h28; s0_in_data = 111'd9; s0_out_ready = 1'b1; s0_flush = 1'b1;
        tick();
        vec_cnt++; if (s1_out_valid !== 1'b0 || s1_out_ctrl !== 8'h00 || s1_count !== 2'd0) begin
            err_cnt++; $display("FAIL flush_s1_state got v=%0b c=%h n=%0d exp v=0 c=00 n=0", s1_out_valid, s1_out_ctrl, s1_count); end
        vec_cnt++; if (s1_in_ready !== 1'b1) begin err_cnt++; $display("FAIL flush_s1_ready got %0b exp 1", s1_in_ready); end
        vec_cnt++; if (s0_out_valid !== 1'b0 || s0_out_ctrl !== 8'h00 || s0_count !== 2'd0) begin
            err_cnt++; $display("FAIL flush_s0_state got v=%0b c=%h n=%0d exp v=0 c=00 n=0", s0_out_valid, s0_out_ctrl, s0_count); end
        s1_flush = 1'b0; s1_in_valid = 1'b0; s1_out_ready = 1'b1;
        s0_flush = 1'b0; s0_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vec_cnt++; if (s1_out_valid !== 1'b0 || s1_count !== 2'd0) begin err_cnt++; $display("FAIL flush_s1_no9 got v=%0b n=%0d exp v=0 n=0", s1_out_valid, s1_count); end
        end
        vec_cnt++; if (s0_out_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_s0_no9 got v=%0b exp 0", s0_out_valid); end
    endtask

    task automatic test_bubble();
        s1_in_valid = 1'b1; s1_in_ctrl = 8'h08; s1_in_data = 111'h33; s1_out_ready = 1'b1;
        s0_in_valid = 1'b1; s0_in_ctrl = 8'h08; s0_in_data = 111'h33; s0_out_ready = 1'b1;
        tick();
        vec_cnt++; if (s1_out_ctrl !== 8'h08 || s1_out_valid !== 1'b1) begin err_cnt++; $display("FAIL bubble_s1_load got c=%h v=%0b exp c=08 v=1", s1_out_ctrl, s1_out_valid); end
        s1_in_valid = 1'b0; s0_in_valid = 1'b0;
        tick();
        vec_cnt++; if (s1_out_ctrl[3] !== 1'b0 || s1_out_valid !== 1'b0) begin err_cnt++; $display("FAIL bubble_s1_drain got c=%h v=%0b exp c=00 v=0", s1_out_ctrl, s1_out_valid); end
        vec_cnt++; if (s1_out_data !== 111'h33) begin err_cnt++; $display("FAIL bubble_s1_data_hold got %h exp 33", s1_out_data); end
        vec_cnt++; if (s0_out_ctrl[3] !== 1'b0 || s0_out_valid !== 1'b0) begin err_cnt++; $display("FAIL bubble_s0_drain got c=%h v=%0b exp c=00 v=0", s0_out_ctrl, s0_out_valid); end
    endtask

    task automatic test_reg_backpressure();
        s0_in_valid = 1'b1; s0_in_ctrl = 8'h28; s0_in_data = 111'h41; s0_out_ready = 1'b1;
        tick();
        vec_cnt++; if (s0_out_valid !== 1'b1 || s0_out_data !== 111'h41) begin err_cnt++; $display("FAIL bp_load got v=%0b d=%h exp v=1 d=41", s0_out_valid, s0_out_data); end
        s0_out_ready = 1'b0; s0_in_data = 111'h42;
        #1;
        vec_cnt++; if (s0_in_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_ready_comb got %0b exp 0", s0_in_ready); end
        tick();
        vec_cnt++; if (s0_out_data !== 111'h41 || s0_count !== 2'd1) begin err_cnt++; $display("FAIL bp_hold got d=%h n=%0d exp d=41 n=1", s0_out_data, s0_count); end
        s0_out_ready = 1'b1;
        #1;
        vec_cnt++; if (s0_in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_ready_up got %0b exp 1", s0_in_ready); end
        tick();
        vec_cnt++; if (s0_out_data !== 111'h42 || s0_count !== 2'd1 || s0_out_valid !== 1'b1) begin
            err_cnt++; $display("FAIL bp_replace got d=%h n=%0d v=%0b exp d=42 n=1 v=1", s0_out_data, s0_count, s0_out_valid); end
        s0_in_valid = 1'b0;
        tick();
        vec_cnt++; if (s0_count !== 2'd0) begin err_cnt++; $display("FAIL bp_drain got %0d exp 0", s0_count); end
    endtask

    task automatic test_async_reset();
        s1_in_valid = 1'b1; s1_in_ctrl = 8'h28; s1_in_data = 111'h51; s1_out_ready = 1'b0;
        tick();
        s1_in_data = 111'h52;
        tick();
        vec_cnt++; if (s1_count !== 2'd2) begin err_cnt++; $display("FAIL arst_fill got %0d exp 2", s1_count); end
        #2;
        rst = 1'b1;
        #1;
        vec_cnt++; if (s1_out_valid !== 1'b0 || s1_out_ctrl !== 8'h00 || s1_count !== 2'd0) begin
            err_cnt++; $display("FAIL arst_clear got v=%0b c=%h n=%0d exp v=0 c=00 n=0", s1_out_valid, s1_out_ctrl, s1_count); end
        vec_cnt++; if (s1_in_ready !== 1'b1) begin err_cnt++; $display("FAIL arst_ready got %0b exp 1", s1_in_ready); end
        s1_in_valid = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        vec_cnt++; if (s1_out_valid !== 1'b0 || s1_count !== 2'd0) begin err_cnt++; $display("FAIL arst_after got v=%0b n=%0d exp v=0 n=0", s1_out_valid, s1_count); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_bubble();
        test_reg_backpressure();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline-stage register for the 5-stage CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid bit, bubble insertion (flush) and backpressure (stall).
- Optional 2-entry skid buffer for a fully registered ready path.
- Control bits and datapath bits are separate buses. Control is forced to zero whenever the stage holds a bubble, so a bubble can never write the register file or memory.

Parameters:
- CTRL_W, 8, width of control bundle (regdst, alusrc, memtoreg, regwrite, memread, memwrite, aluop[1:0]).
- DATA_W, 111, width of data bundle (RS, RT, signextend, RSaddr, RTaddr, RDaddr).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready_o; 0 = single register with combinational ready.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  discard all held entries and the incoming beat this cycle.
- in_valid_i  in  1  upstream beat present.
- in_ready_o  out  1  stage accepts a beat this cycle.
- in_ctrl_i  in  CTRL_W  upstream control bundle.
- in_data_i  in  DATA_W  upstream data bundle.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts head (0 = stall).
- out_ctrl_o  out  CTRL_W  head control; all-zero when out_valid_o=0.
- out_data_o  out  DATA_W  head data; holds last value when invalid (don't-care).
- count_o  out  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Reset (async assert, release synchronous to clk_i):
  - out_valid_o=0, out_ctrl_o=0, out_data_o=0, count_o=0.
  - in_ready_o=1 once rst_i is low.
- Handshakes:
  - Accept occurs when in_valid_i & in_ready_o at a rising edge.
  - Release occurs when out_valid_o & out_ready_i at a rising edge.
- Latency: 1 cycle. A beat accepted at edge N appears on out_* after edge N if the stage was empty. There is no combinational in->out path in either mode.
- SKID=0:
  - in_ready_o = ~out_valid_o | out_ready_i (combinational from out_ready_i).
  - On accept: head <= input, valid <= 1.
  - On release without accept: valid <= 0, ctrl <= 0.
  - When out_valid_o=1 and out_ready_i=0: head holds.
- SKID=1:
  - Two entries, head (H) and skid (S). in_ready_o is a flop: 1 iff S is empty after the current edge.
  - States:
    - EMPTY (count 0): accept -> ONE.
    - ONE (count 1):
      - accept & release -> ONE, H <= input.
      - accept & ~release -> FULL, S <= input.
      - release & ~accept -> EMPTY.
    - FULL (count 2), in_ready_o=0:
      - release -> ONE, H <= S.
      - Input is not accepted in FULL.
  - Ordering is strictly FIFO. No beat is duplicated or dropped except by flush.
- Flush:
  - flush_i=1 at an edge: next state EMPTY, count_o=0, out_valid_o=0, out_ctrl_o=0.
  - The incoming beat is discarded even if in_valid_i & in_ready_o.
  - A simultaneous release still counts as taken by downstream.
  - Flush has priority over accept, release and stall.
  - in_ready_o=1 in the cycle after a flush.
- Bubble rule: out_ctrl_o is zero at every edge where out_valid_o=0. This holds after reset, after flush and after drain. out_data_o is not cleared on drain.
- Reset mid-operation: all entries are lost immediately (asynchronous); outputs go to reset values within the same cycle.
- count_o always equals the number of valid entries; it never reaches 2 when SKID=0.

Decomposition:
- Shared package pipe_pkg holds:
  - CTRL bit-position constants: REGDST=0, ALUSRC=1, MEMTOREG=2, REGWRITE=3, MEMREAD=4, MEMWRITE=5, ALUOP=7:6.
  - CTRL_W/DATA_W defaults per stage (IFID, IDEX, EXMEM, MEMWB).
  - The all-zero bubble constant.
- One sub-module, pipe_skid_buf: the 2-entry H/S storage plus count logic. It is instantiated only under SKID=1; the SKID=0 path is inline.

Test Plan:
- Reset then stream: rst_i pulse, then in_valid_i=1 with ctrl 8'h28 / data 1..4 on consecutive cycles and out_ready_i=1 -> out_* shows the same sequence 1 cycle later; count_o=1 throughout; out_ctrl_o=0 before the first beat.
- Stall (SKID=1): stream 5,6,7 with out_ready_i=0 from the 2nd cycle -> count_o goes 1,2; in_ready_o=0 after 6 is accepted; 7 is held upstream. Raise out_ready_i -> out shows 5,6,7 in order, no loss.
- Flush with full buffer: count_o=2, flush_i=1 together with in_valid_i=1 (data 9) -> next cycle out_valid_o=0, out_ctrl_o=0, count_o=0, in_ready_o=1; 9 never appears at the output.
- Bubble safety: ctrl 8'h08 (regwrite) accepted, then in_valid_i=0 with out_ready_i=1 -> after drain out_ctrl_o[REGWRITE]=0 and out_valid_o=0.
- SKID=0 backpressure: out_valid_o=1, out_ready_i=0 -> in_ready_o=0 in the same cycle. out_ready_i=1 with in_valid_i=1 -> head replaced in 1 cycle, count_o stays 1.
- Async reset mid-stream: assert rst_i between edges while count_o=2 -> out_valid_o=0, out_ctrl_o=0 and count_o=0 before the next edge.
